// File: rtl/pc_sequencer.sv
// Run-control and next-PC sequencer for ProgCtr: start, hold, jump, call and return,
// with a small return-address stack and run/done/error status.
module pc_sequencer #(
    parameter int A = 10,
    parameter int D = 4
) (
    input  logic         Clk,
    input  logic         Rst_n,
    input  logic         Go,
    input  logic         Halt,
    input  logic         Stall,
    input  logic         BrTaken,
    input  logic         Call,
    input  logic         Ret,
    input  logic [A-1:0] BrTarget,
    input  logic [A-1:0] PC,
    output logic         PcStart,
    output logic         PcBranch,
    output logic [A-1:0] PcTarget,
    output logic         Running,
    output logic         Done,
    output logic         StackErr
);

    // state | meaning
    // IDLE  | hold ProgCtr at 0 (Start), wait for Go
    // RUN   | program executing, next PC chosen by priority
    // DONE  | halted, PC frozen at halt address until Go
    // ERR   | stack over/underflow, PC frozen until Go
    typedef enum logic [1:0] {IDLE, RUN, DONE, ERR} state_t;

    localparam int SPW = $clog2(D + 1);
    localparam int IW  = (D > 1) ? $clog2(D) : 1;

    state_t         state, state_nxt;
    logic [SPW-1:0] sp, sp_nxt;
    logic           push;
    logic [A-1:0]   stk [D];
    logic [A-1:0]   pc_inc;
    logic [SPW-1:0] sp_dec;

    assign pc_inc = PC + A'(1);
    assign sp_dec = sp - SPW'(1);

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state <= IDLE;
            sp    <= '0;
        end else begin
            state <= state_nxt;
            sp    <= sp_nxt;
        end
    end

    // Stack contents are deliberately not reset; only sp qualifies them.
    always_ff @(posedge Clk) begin
        if (push)
            stk[sp[IW-1:0]] <= pc_inc;
    end

    always_comb begin
        state_nxt = state;
        sp_nxt    = sp;
        push      = 1'b0;
        PcStart   = 1'b0;
        PcBranch  = 1'b0;
        PcTarget  = '0;
        case (state)
            IDLE: begin
                PcStart = 1'b1;
                if (Go) begin
                    state_nxt = RUN;
                    sp_nxt    = '0;
                end
            end
            RUN: begin
                if (Halt) begin
                    PcBranch  = 1'b1;
                    PcTarget  = PC;
                    state_nxt = DONE;
                end else if (Stall) begin
                    PcBranch = 1'b1;
                    PcTarget = PC;
                end else if (Ret) begin
                    PcBranch = 1'b1;
                    if (sp == '0) begin
                        PcTarget  = PC;
                        state_nxt = ERR;
                    end else begin
                        PcTarget = stk[sp_dec[IW-1:0]];
                        sp_nxt   = sp_dec;
                    end
                end else if (Call) begin
                    PcBranch = 1'b1;
                    if (sp == SPW'(D)) begin
                        PcTarget  = PC;
                        state_nxt = ERR;
                    end else begin
                        PcTarget = BrTarget;
                        push     = 1'b1;
                        sp_nxt   = sp + SPW'(1);
                    end
                end else if (BrTaken) begin
                    PcBranch = 1'b1;
                    PcTarget = BrTarget;
                end
            end
            DONE, ERR: begin
                if (Go) begin
                    PcStart   = 1'b1;
                    state_nxt = RUN;
                    sp_nxt    = '0;
                end else begin
                    PcBranch = 1'b1;
                    PcTarget = PC;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign Running  = (state == RUN);
    assign Done     = (state == DONE);
    assign StackErr = (state == ERR);

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer driving a behavioural ProgCtr; expected PC/status
// per cycle is queued at drive time and compared after the following edge.
module tb_pc_sequencer;

    localparam int A = 10;
    localparam int D = 4;

    localparam logic [5:0] N   = 6'b000000;
    localparam logic [5:0] GO  = 6'b100000;
    localparam logic [5:0] HLT = 6'b010000;
    localparam logic [5:0] STL = 6'b001000;
    localparam logic [5:0] BR  = 6'b000100;
    localparam logic [5:0] CL  = 6'b000010;
    localparam logic [5:0] RT  = 6'b000001;

    localparam logic [2:0] F_IDLE = 3'b000;
    localparam logic [2:0] F_RUN  = 3'b100;
    localparam logic [2:0] F_DONE = 3'b010;
    localparam logic [2:0] F_ERR  = 3'b001;

    logic         Clk = 1'b0;
    logic         Rst_n;
    logic         Go, Halt, Stall, BrTaken, Call, Ret;
    logic [A-1:0] BrTarget;
    logic [A-1:0] pc = '0;
    logic         PcStart, PcBranch, Running, Done, StackErr;
    logic [A-1:0] PcTarget;

    int checks = 0;
    int errors = 0;
    logic [A+2:0] sb_q[$];

    pc_sequencer #(.A(A), .D(D)) dut (
        .Clk(Clk), .Rst_n(Rst_n), .Go(Go), .Halt(Halt), .Stall(Stall),
        .BrTaken(BrTaken), .Call(Call), .Ret(Ret), .BrTarget(BrTarget), .PC(pc),
        .PcStart(PcStart), .PcBranch(PcBranch), .PcTarget(PcTarget),
        .Running(Running), .Done(Done), .StackErr(StackErr)
    );

    always #5 Clk = ~Clk;

    // Behavioural ProgCtr: Start clears, Branch loads Target, otherwise increment.
    always @(posedge Clk) begin
        if (PcStart)       pc <= '0;
        else if (PcBranch) pc <= PcTarget;
        else               pc <= pc + 10'd1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs, queue the expected post-edge PC and status.
    task automatic step(input string tag, input logic [5:0] ctl, input logic [A-1:0] tgt,
                        input logic [A-1:0] exp_pc, input logic [2:0] exp_fl);
        logic [A+2:0] e;
        {Go, Halt, Stall, BrTaken, Call, Ret} = ctl;
        BrTarget = tgt;
        sb_q.push_back({exp_pc, exp_fl});
        @(posedge Clk);
        #1;
        e = sb_q.pop_front();
        check({tag, ".pc"}, 32'(pc), 32'(e[A+2:3]));
        check({tag, ".st"}, 32'({Running, Done, StackErr}), 32'(e[2:0]));
    endtask

    task automatic check_comb(input string tag, input logic st, input logic br,
                              input logic [A-1:0] tg);
        check({tag, ".start"}, 32'(PcStart), 32'(st));
        check({tag, ".branch"}, 32'(PcBranch), 32'(br));
        check({tag, ".target"}, 32'(PcTarget), 32'(tg));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        Rst_n = 1'b0;
        {Go, Halt, Stall, BrTaken, Call, Ret} = N;
        BrTarget = '0;
        repeat (2) @(posedge Clk);
        #1;
        check_comb("rst", 1'b1, 1'b0, 10'h000);
        check("rst.st", 32'({Running, Done, StackErr}), 32'(F_IDLE));
        Rst_n = 1'b1;
        #1;
        check_comb("idle", 1'b1, 1'b0, 10'h000);

        step("idle", N, 10'h000, 10'h000, F_IDLE);
        step("go", GO, 10'h000, 10'h000, F_RUN);
        step("seq1", N, 10'h000, 10'h001, F_RUN);
        step("seq2", N, 10'h000, 10'h002, F_RUN);
        step("seq3", N, 10'h000, 10'h003, F_RUN);
        step("halt", HLT, 10'h000, 10'h003, F_DONE);
        for (int i = 0; i < 10; i++)
            step("done_hold", (i % 2 == 0) ? BR : CL, 10'h123, 10'h003, F_DONE);
        check_comb("done", 1'b0, 1'b1, 10'h003);

        step("go_done", GO, 10'h000, 10'h000, F_RUN);
        for (int i = 1; i <= 5; i++)
            step("to5", N, 10'h000, 10'(i), F_RUN);
        step("jump", BR, 10'h020, 10'h020, F_RUN);
        step("stall1", STL, 10'h000, 10'h020, F_RUN);
        step("stall_call", STL | CL, 10'h300, 10'h020, F_RUN);
        step("stall3", STL | BR, 10'h111, 10'h020, F_RUN);
        step("after_stall", N, 10'h000, 10'h021, F_RUN);
        step("ret_empty", RT, 10'h000, 10'h021, F_ERR);
        check_comb("err", 1'b0, 1'b1, 10'h021);
        step("err_hold", BR, 10'h055, 10'h021, F_ERR);
        step("go_err", GO, 10'h000, 10'h000, F_RUN);

        step("to10", BR, 10'h010, 10'h010, F_RUN);
        step("call40", CL, 10'h040, 10'h040, F_RUN);
        step("at41", N, 10'h000, 10'h041, F_RUN);
        step("call80", CL, 10'h080, 10'h080, F_RUN);
        step("ret42", RT, 10'h000, 10'h042, F_RUN);
        step("ret11", RT, 10'h000, 10'h011, F_RUN);
        step("sp0", RT, 10'h000, 10'h011, F_ERR);
        step("go2", GO, 10'h000, 10'h000, F_RUN);

        for (int i = 0; i < D; i++)
            step("deep_call", CL, 10'h100 + 10'(i), 10'h100 + 10'(i), F_RUN);
        step("overflow", CL, 10'h1F0, 10'h103, F_ERR);
        check_comb("ovf", 1'b0, 1'b1, 10'h103);
        step("ovf_hold", N, 10'h000, 10'h103, F_ERR);
        check_comb("go_err_comb", 1'b0, 1'b1, 10'h103);
        step("go3", GO, 10'h000, 10'h000, F_RUN);
        step("sp_after_go", RT, 10'h000, 10'h000, F_ERR);
        step("go4", GO, 10'h000, 10'h000, F_RUN);

        step("call50", CL, 10'h050, 10'h050, F_RUN);
        step("call_ret", CL | RT, 10'h060, 10'h001, F_RUN);
        step("cr_sp0", RT, 10'h000, 10'h001, F_ERR);
        step("go5", GO, 10'h000, 10'h000, F_RUN);
        step("halt_br", HLT | BR, 10'h070, 10'h000, F_DONE);
        step("hb_hold", N, 10'h000, 10'h000, F_DONE);
        step("go6", GO, 10'h000, 10'h000, F_RUN);

        step("to3ff", BR, 10'h3FF, 10'h3FF, F_RUN);
        step("call_wrap", CL, 10'h010, 10'h010, F_RUN);
        step("ret_wrap", RT, 10'h000, 10'h000, F_RUN);
        step("after_wrap", N, 10'h000, 10'h001, F_RUN);

        step("call30", CL, 10'h030, 10'h030, F_RUN);
        step("call55", CL, 10'h055, 10'h055, F_RUN);
        Rst_n = 1'b0;
        {Go, Halt, Stall, BrTaken, Call, Ret} = BR | CL;
        BrTarget = 10'h2AA;
        #1;
        check_comb("async_rst", 1'b1, 1'b0, 10'h000);
        check("async_rst.st", 32'({Running, Done, StackErr}), 32'(F_IDLE));
        @(posedge Clk);
        #1;
        check("async_rst.pc", 32'(pc), 32'h0);
        Rst_n = 1'b1;
        step("post_rst", N, 10'h000, 10'h000, F_IDLE);
        step("go7", GO, 10'h000, 10'h000, F_RUN);
        step("rst_sp0", RT, 10'h000, 10'h000, F_ERR);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
